// File: rtl/gm_bridge_pkg.sv
// ---------------------------------------------------------------------------
// gm_bridge_pkg
// Shared definitions for the general-arbiter SRAM bridge slice:
//   - bridgeState_t   : bridge FSM states (IDLE, READ_WAIT)
//   - clog2           : ceiling log2 helper usable in constant expressions
//   - BYTE_LANES      : byte lanes of the default memory word width
//   - mapAddress      : arbiter byte address to SRAM word address mapping
// ---------------------------------------------------------------------------
package gm_bridge_pkg;

   // IDLE means no read is in flight; READ_WAIT covers the whole time a
   // read is travelling through the SRAM and the return pipeline.
   typedef enum logic {
      IDLE      = 1'b0,
      READ_WAIT = 1'b1
   } bridgeState_t;

   localparam int GM_MEM_WIDTH_DEFAULT = 32;
   localparam int BYTE_LANES           = GM_MEM_WIDTH_DEFAULT / 8;

   // Smallest n with 2**n >= value; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

   // Byte address relative to the window base, shifted down to a word
   // index. The caller truncates to its SRAM address width; the low byte
   // offset bits simply fall off in the shift.
   function automatic logic [63:0] mapAddress(input logic [63:0] byteAddress,
                                              input logic [63:0] baseAddress,
                                              input int          offsetBits);
      return (byteAddress - baseAddress) >> offsetBits;
   endfunction

endpackage

// File: rtl/gm_read_latency_tracker.sv
// ---------------------------------------------------------------------------
// gm_read_latency_tracker
// Tracks one outstanding SRAM read with a fixed latency and hands the read
// data back to the arbiter as a one-cycle valid pulse.
//
// Ports:
//   iClk           : clock, rising edge
//   iReset         : synchronous active-high reset, drops any read in flight
//   iIssue         : a read is being issued to the SRAM this cycle
//   iMemReadData   : SRAM read data, valid MEM_READ_LATENCY cycles after issue
//   oReadData      : captured read data, holds between pulses
//   oReadDataValid : one-cycle pulse, oReadData carries new data
//   oRetire        : the bridge FSM may return to IDLE at the next edge
//
// Optional feature macro: GM_SRAM_BRIDGE_RDATA_REG_EN adds one more register
// stage on oReadData/oReadDataValid (one extra cycle of read latency).
// MEM_READ_LATENCY is expected in the range 1..4.
// ---------------------------------------------------------------------------
module gm_read_latency_tracker
   import gm_bridge_pkg::*;
#(
   parameter int D_WIDTH          = 32,
   parameter int MEM_READ_LATENCY = 1
) (
   input  logic               iClk,
   input  logic               iReset,
   input  logic               iIssue,
   input  logic [D_WIDTH-1:0] iMemReadData,
   output logic [D_WIDTH-1:0] oReadData,
   output logic               oReadDataValid,
   output logic               oRetire
);

   localparam int CNT_WIDTH = (clog2(MEM_READ_LATENCY + 1) < 1) ? 1 : clog2(MEM_READ_LATENCY + 1);

   logic [CNT_WIDTH-1:0] count;
   logic                 stageValid;
   logic [D_WIDTH-1:0]   stageData;
   logic                 sampleNow;

   // The counter holds MEM_READ_LATENCY in the first cycle after issue and
   // reaches 1 in the cycle where the SRAM presents the data; that is the
   // cycle we capture it, so the counter lands on 0 at the same edge.
   assign sampleNow = (count == CNT_WIDTH'(1));

   // Latency counter and first return stage. The issue logic guarantees a
   // new read never arrives while the counter is still running.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         count      <= '0;
         stageValid <= 1'b0;
         stageData  <= '0;
      end else begin
         stageValid <= 1'b0;
         if (iIssue) begin
            count <= CNT_WIDTH'(MEM_READ_LATENCY);
         end else if (count != '0) begin
            count <= count - CNT_WIDTH'(1);
            if (sampleNow) begin
               stageValid <= 1'b1;
               stageData  <= iMemReadData;
            end
         end
      end
   end

`ifdef GM_SRAM_BRIDGE_RDATA_REG_EN
   logic               outValid;
   logic [D_WIDTH-1:0] outData;

   // Extra output register; data only moves on a pulse so the arbiter
   // keeps seeing the last read value between reads.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         outValid <= 1'b0;
         outData  <= '0;
      end else begin
         outValid <= stageValid;
         if (stageValid) begin
            outData <= stageData;
         end
      end
   end

   assign oReadData      = outData;
   assign oReadDataValid = outValid;
   // The read is complete only once the delayed pulse has gone out.
   assign oRetire        = outValid;
`else
   assign oReadData      = stageData;
   assign oReadDataValid = stageValid;
   // Leave READ_WAIT at the capture edge so IDLE coincides with the pulse.
   assign oRetire        = sampleNow;
`endif

endmodule

// File: rtl/gm_sram_bridge.sv
// ---------------------------------------------------------------------------
// gm_sram_bridge
// Peripheral-side stage behind the general arbiter. Turns the arbiter's
// read/write request handshake into single-port synchronous SRAM accesses,
// resolves read/write conflicts round robin and tracks read latency.
//
// Ports:
//   iClk, iReset                 : clock (rising edge), synchronous active-high reset
//   iReadRequest, iReadEnable    : read request and qualifier (both needed)
//   iReadAddress                 : read byte address
//   iWriteRequest, iWriteAddress : write request and byte address
//   iWriteEnable, iWriteData     : write byte-lane mask and data
//   oWriteAccept                 : combinational pulse, write performed this cycle
//   oReadDataValid, oReadData    : read return pulse and data (data holds)
//   oMemAddress                  : SRAM word address
//   oMemReadEnable               : SRAM read strobe
//   oMemWriteEnable              : SRAM byte write strobes
//   oMemWriteData                : SRAM write data
//   iMemReadData                 : SRAM read data
//
// Optional feature macro: GM_SRAM_BRIDGE_RDATA_REG_EN (extra read data
// register stage, see gm_read_latency_tracker).
// ---------------------------------------------------------------------------
module gm_sram_bridge
   import gm_bridge_pkg::*;
#(
   parameter int                     D_WIDTH          = 32,
   parameter int                     GM_ADDR_WIDTH    = 32,
   parameter int                     GM_MEM_WIDTH     = GM_MEM_WIDTH_DEFAULT,
   parameter int                     MEM_ADDR_WIDTH   = 10,
   parameter logic [GM_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                     MEM_READ_LATENCY = 1
) (
   input  logic                      iClk,
   input  logic                      iReset,
   input  logic                      iReadRequest,
   input  logic                      iReadEnable,
   input  logic [GM_ADDR_WIDTH-1:0]  iReadAddress,
   input  logic                      iWriteRequest,
   input  logic [GM_ADDR_WIDTH-1:0]  iWriteAddress,
   input  logic [GM_MEM_WIDTH/8-1:0] iWriteEnable,
   input  logic [D_WIDTH-1:0]        iWriteData,
   output logic                      oWriteAccept,
   output logic                      oReadDataValid,
   output logic [D_WIDTH-1:0]        oReadData,
   output logic [MEM_ADDR_WIDTH-1:0] oMemAddress,
   output logic                      oMemReadEnable,
   output logic [GM_MEM_WIDTH/8-1:0] oMemWriteEnable,
   output logic [D_WIDTH-1:0]        oMemWriteData,
   input  logic [D_WIDTH-1:0]        iMemReadData
);

   localparam int OFFSET_BITS = clog2(GM_MEM_WIDTH / 8);

   bridgeState_t              state;
   logic                      rPrioRead;
   logic                      readEligible;
   logic                      writeEligible;
   logic                      grantRead;
   logic                      grantWrite;
   logic                      trackerRetire;
   logic [MEM_ADDR_WIDTH-1:0] readWordAddress;
   logic [MEM_ADDR_WIDTH-1:0] writeWordAddress;

   assign readWordAddress  = MEM_ADDR_WIDTH'(mapAddress(64'(iReadAddress), 64'(BASE_ADDR), OFFSET_BITS));
   assign writeWordAddress = MEM_ADDR_WIDTH'(mapAddress(64'(iWriteAddress), 64'(BASE_ADDR), OFFSET_BITS));

   // Issue decision. Only one read may be in flight, and the valid cycle is
   // excluded so a request the arbiter is just retiring is not reissued.
   // Nothing issues while reset is asserted so the SRAM sees idle strobes.
   always_comb begin
      readEligible  = !iReset && (state == IDLE) && iReadRequest && iReadEnable && !oReadDataValid;
      writeEligible = !iReset && iWriteRequest;
      grantRead     = readEligible && (!writeEligible || rPrioRead);
      grantWrite    = writeEligible && (!readEligible || !rPrioRead);
   end

   // Memory-side strobes and the write accept follow the grant in the same
   // cycle; everything is driven to zero when nothing is granted.
   always_comb begin
      oMemAddress     = '0;
      oMemReadEnable  = 1'b0;
      oMemWriteEnable = '0;
      oMemWriteData   = '0;
      oWriteAccept    = 1'b0;
      if (grantWrite) begin
         oMemAddress     = writeWordAddress;
         oMemWriteEnable = iWriteEnable;
         oMemWriteData   = iWriteData;
         oWriteAccept    = 1'b1;
      end else if (grantRead) begin
         oMemAddress    = readWordAddress;
         oMemReadEnable = 1'b1;
      end
   end

   // Bridge FSM plus the round-robin priority bit. Priority only flips when
   // both sides actually competed, so an uncontested access never steals a
   // turn from the other side.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state     <= IDLE;
         rPrioRead <= 1'b1;
      end else begin
         if (readEligible && writeEligible) begin
            rPrioRead <= ~rPrioRead;
         end
         case (state)
            IDLE:      if (grantRead)     state <= READ_WAIT;
            READ_WAIT: if (trackerRetire) state <= IDLE;
            default:                      state <= IDLE;
         endcase
      end
   end

   gm_read_latency_tracker #(
      .D_WIDTH          (D_WIDTH),
      .MEM_READ_LATENCY (MEM_READ_LATENCY)
   ) uTracker (
      .iClk           (iClk),
      .iReset         (iReset),
      .iIssue         (grantRead),
      .iMemReadData   (iMemReadData),
      .oReadData      (oReadData),
      .oReadDataValid (oReadDataValid),
      .oRetire        (trackerRetire)
   );

endmodule

// File: tb/tb_gm_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_gm_sram_bridge
// Directed and randomized checks of gm_sram_bridge against a word-array
// reference of the SRAM contents, with a simple fixed-latency SRAM model.
// ---------------------------------------------------------------------------
module tb_gm_sram_bridge;

   localparam int          LAT  = 3;
   localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef GM_SRAM_BRIDGE_RDATA_REG_EN
   localparam int          EXPLAT = LAT + 2;
`else
   localparam int          EXPLAT = LAT + 1;
`endif

   logic        iClk;
   logic        iReset;
   logic        iReadRequest;
   logic        iReadEnable;
   logic [31:0] iReadAddress;
   logic        iWriteRequest;
   logic [31:0] iWriteAddress;
   logic [3:0]  iWriteEnable;
   logic [31:0] iWriteData;
   logic        oWriteAccept;
   logic        oReadDataValid;
   logic [31:0] oReadData;
   logic [9:0]  oMemAddress;
   logic        oMemReadEnable;
   logic [3:0]  oMemWriteEnable;
   logic [31:0] oMemWriteData;
   logic [31:0] iMemReadData;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] refMem [16];
   logic [31:0] sram   [1024];
   logic [31:0] rdPipe [LAT];

   gm_sram_bridge #(
      .D_WIDTH          (32),
      .GM_ADDR_WIDTH    (32),
      .GM_MEM_WIDTH     (32),
      .MEM_ADDR_WIDTH   (10),
      .BASE_ADDR        (BASE),
      .MEM_READ_LATENCY (LAT)
   ) dut (
      .iClk            (iClk),
      .iReset          (iReset),
      .iReadRequest    (iReadRequest),
      .iReadEnable     (iReadEnable),
      .iReadAddress    (iReadAddress),
      .iWriteRequest   (iWriteRequest),
      .iWriteAddress   (iWriteAddress),
      .iWriteEnable    (iWriteEnable),
      .iWriteData      (iWriteData),
      .oWriteAccept    (oWriteAccept),
      .oReadDataValid  (oReadDataValid),
      .oReadData       (oReadData),
      .oMemAddress     (oMemAddress),
      .oMemReadEnable  (oMemReadEnable),
      .oMemWriteEnable (oMemWriteEnable),
      .oMemWriteData   (oMemWriteData),
      .iMemReadData    (iMemReadData)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // SRAM model: byte-lane writes, read data presented LAT cycles after the
   // strobe and garbage otherwise, so a mistimed capture shows up.
   always @(posedge iClk) begin
      for (int b = 0; b < 4; b++) begin
         if (oMemWriteEnable[b]) sram[oMemAddress][8*b +: 8] <= oMemWriteData[8*b +: 8];
      end
      rdPipe[0] <= oMemReadEnable ? sram[oMemAddress] : $urandom();
      for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
   end
   assign iMemReadData = rdPipe[LAT-1];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int wordOf(input logic [31:0] addr);
      return int'((addr - BASE) / 4);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] mask);
      logic [31:0] result;
      result = old;
      for (int b = 0; b < 4; b++) if (mask[b]) result[8*b +: 8] = data[8*b +: 8];
      return result;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Drives one cycle's request inputs at the falling edge, then settles.
   task automatic applyStimulus(input logic rd, input logic [31:0] ra, input logic wr,
                                input logic [31:0] wa, input logic [3:0] mask, input logic [31:0] data);
      @(negedge iClk);
      iReadRequest  = rd;
      iReadEnable   = rd;
      iReadAddress  = ra;
      iWriteRequest = wr;
      iWriteAddress = wa;
      iWriteEnable  = mask;
      iWriteData    = data;
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " valid"},  32'(oReadDataValid), 0);
      checkOutput({tag, " rdata"},  oReadData, 0);
      checkOutput({tag, " accept"}, 32'(oWriteAccept), 0);
      checkOutput({tag, " memre"},  32'(oMemReadEnable), 0);
      checkOutput({tag, " memwe"},  32'(oMemWriteEnable), 0);
      checkOutput({tag, " memaddr"}, 32'(oMemAddress), 0);
   endtask

   // Waits for the read return; elapsed = cycles since issue already spent.
   task automatic waitValid(input logic [31:0] expData, input int elapsed, input string tag);
      int   n;
      logic seen;
      n    = elapsed;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge iClk);
         #1;
         n++;
         if (oReadDataValid) seen = 1'b1;
         else checkOutput({tag, " no reissue"}, 32'(oMemReadEnable), 0);
      end
      checkOutput({tag, " seen"}, 32'(seen), 1);
      checkOutput({tag, " latency"}, 32'(n), 32'(EXPLAT));
      checkOutput({tag, " data"}, oReadData, expData);
      iReadRequest = 1'b0;
      iReadEnable  = 1'b0;
   endtask

   task automatic doWrite(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data, input string tag);
      applyStimulus(1'b0, '0, 1'b1, addr, mask, data);
      checkOutput({tag, " accept"}, 32'(oWriteAccept), 1);
      checkOutput({tag, " addr"}, 32'(oMemAddress), 32'(wordOf(addr)));
      checkOutput({tag, " strobe"}, 32'(oMemWriteEnable), 32'(mask));
      refMem[wordOf(addr)] = merge(refMem[wordOf(addr)], data, mask);
      @(posedge iClk);
      #1;
      iWriteRequest = 1'b0;
   endtask

   task automatic doRead(input logic [31:0] addr, input string tag);
      applyStimulus(1'b1, addr, 1'b0, '0, '0, '0);
      checkOutput({tag, " issue"}, 32'(oMemReadEnable), 1);
      checkOutput({tag, " addr"}, 32'(oMemAddress), 32'(wordOf(addr)));
      waitValid(refMem[wordOf(addr)], 0, tag);
   endtask

   task automatic conflict(input logic readWins, input logic [31:0] ra, input logic [31:0] wa,
                           input logic [31:0] data, input string tag);
      logic [31:0] expR;
      applyStimulus(1'b1, ra, 1'b1, wa, 4'hF, data);
      checkOutput({tag, " read grant"},  32'(oMemReadEnable), 32'(readWins));
      checkOutput({tag, " write grant"}, 32'(oWriteAccept), 32'(!readWins));
      if (readWins) begin
         expR = refMem[wordOf(ra)];
         @(negedge iClk);
         #1;
         checkOutput({tag, " late write"}, 32'(oWriteAccept), 1);
         refMem[wordOf(wa)] = data;
         @(posedge iClk);
         #1;
         iWriteRequest = 1'b0;
         waitValid(expR, 1, tag);
      end else begin
         refMem[wordOf(wa)] = data;
         @(posedge iClk);
         #1;
         iWriteRequest = 1'b0;
         @(negedge iClk);
         #1;
         checkOutput({tag, " late read"}, 32'(oMemReadEnable), 1);
         waitValid(refMem[wordOf(ra)], 0, tag);
      end
   endtask

   function automatic logic [31:0] randAddr();
      return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [31:0] expR;
      for (int i = 0; i < 1024; i++) sram[i] = '0;
      for (int i = 0; i < 16; i++) refMem[i] = '0;
      iReset = 1'b1;
      iReadRequest = 0; iReadEnable = 0; iReadAddress = 0;
      iWriteRequest = 0; iWriteAddress = 0; iWriteEnable = 0; iWriteData = 0;
      repeat (2) @(negedge iClk);
      #1;
      checkAllZero("reset");
      iReset = 1'b0;

      // Directed write/read at the window base offset
      doWrite(32'h0000_1008, 4'hF, 32'hDEAD_BEEF, "wr1");
      doRead(32'h0000_1008, "rd1");
      checkOutput("rd1 const", oReadData, 32'hDEAD_BEEF);

      // Byte-lane merge; low offset bits of the address are ignored
      doWrite(32'h0000_1010, 4'hF, 32'h1122_3344, "wrfull");
      doWrite(32'h0000_1011, 4'b0010, 32'h0000_AB00, "wrlane");
      doRead(32'h0000_1010, "rdlane");
      checkOutput("rdlane const", oReadData, 32'h1122_AB44);

      // Zero mask is accepted but changes nothing
      doWrite(32'h0000_1010, 4'h0, 32'hFFFF_FFFF, "wrzero");
      doRead(32'h0000_1010, "rdzero");

      // Request without qualifier must not issue
      @(negedge iClk);
      iReadRequest = 1'b1; iReadEnable = 1'b0; iReadAddress = 32'h0000_1008;
      #1;
      checkOutput("noqual memre", 32'(oMemReadEnable), 0);
      @(posedge iClk);
      #1;
      iReadRequest = 1'b0;

      // Write issued the cycle after a read issue, read still held
      doWrite(32'h0000_1020, 4'hF, 32'h5555_AAAA, "ovpre");
      applyStimulus(1'b1, 32'h0000_1020, 1'b0, '0, '0, '0);
      checkOutput("overlap issue", 32'(oMemReadEnable), 1);
      expR = refMem[wordOf(32'h0000_1020)];
      applyStimulus(1'b1, 32'h0000_1020, 1'b1, 32'h0000_1024, 4'hF, 32'h0BAD_F00D);
      checkOutput("overlap wr accept", 32'(oWriteAccept), 1);
      checkOutput("overlap no reread", 32'(oMemReadEnable), 0);
      refMem[wordOf(32'h0000_1024)] = 32'h0BAD_F00D;
      @(posedge iClk);
      #1;
      iWriteRequest = 1'b0;
      waitValid(expR, 1, "overlap");
      checkOutput("overlap const", oReadData, 32'h5555_AAAA);
      doRead(32'h0000_1024, "ovpost");

      // Reset one cycle after a read issue drops the read
      applyStimulus(1'b1, 32'h0000_1008, 1'b0, '0, '0, '0);
      checkOutput("rst issue", 32'(oMemReadEnable), 1);
      @(negedge iClk);
      iReset = 1'b1; iReadRequest = 1'b0; iReadEnable = 1'b0;
      @(negedge iClk);
      iReset = 1'b0;
      #1;
      checkAllZero("midreset");
      for (int i = 0; i < 8; i++) begin
         @(negedge iClk);
         #1;
         checkOutput("midreset no valid", 32'(oReadDataValid), 0);
      end
      doRead(32'h0000_1008, "postrst");

      // Randomized traffic against the reference array
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 1) doWrite(randAddr(), 4'($urandom_range(0, 15)), $urandom(), "rndwr");
         else doRead(randAddr(), "rndrd");
      end

      // Round-robin conflicts from a fresh reset: R, W, R, W
      @(negedge iClk);
      iReset = 1'b1;
      @(negedge iClk);
      iReset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         conflict((i % 2) == 0, BASE + 32'(8 * i), BASE + 32'(8 * i + 4), $urandom(), "conflict");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
